// File: rtl/clk_div_pkg.sv
// Shared types, limits and helpers for the clock-divider controller.
package clk_div_pkg;

  // Controller modes: halted, counting, counting with a config waiting for the wrap.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } ctrl_state_t;

  // Smallest divide ratio that still gives a counter with a distinct last count.
  localparam int MIN_DIV = 2;

  // Config fields are widened to this width before checking; fields up to 32 bits are supported.
  localparam int CFG_ARG_W = 32;

  // A config is usable when the ratio is at least MIN_DIV and the high time fits in the period.
  function automatic logic cfg_ok(input logic [CFG_ARG_W-1:0] div,
                                  input logic [CFG_ARG_W-1:0] duty);
    return (div >= CFG_ARG_W'(MIN_DIV)) && (duty <= div);
  endfunction

endpackage

// File: rtl/clk_div_ctrl_core.sv
// Period counter and duty compare. The controller guarantees act_div/act_duty only
// change while the counter is at (or about to return to) zero.
module div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             run,
  input  logic [CNT_W-1:0] act_div,
  input  logic [CNT_W-1:0] act_duty,
  output logic             clk_div,
  output logic             period_start,
  output logic             last
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // act_div >= 2 is guaranteed upstream, so act_div - 1 never wraps below zero.
  assign last = (cnt == act_div - ONE);

  // Count through the period; outputs are registered so they lag the counter by one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst || !run) begin
      cnt          <= '0;
      clk_div      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cnt          <= last ? '0 : cnt + ONE;
      clk_div      <= (cnt < act_duty);
      period_start <= (cnt == '0);
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider with duty control. New settings arrive over a
// valid/ready handshake and only take effect at a period boundary (or while halted).
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = 16,
  parameter int DEF_DUTY = 4
)
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [CNT_W-1:0] i_cfg_div,
  input  logic [CNT_W-1:0] i_cfg_duty,
  output logic             o_cfg_err,
  output logic             o_clk_div,
  output logic             o_period_start,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_cur_div,
  output logic [CNT_W-1:0] o_cur_duty
);

  ctrl_state_t      state;
  ctrl_state_t      state_nxt;

  logic [CNT_W-1:0] act_div;
  logic [CNT_W-1:0] act_duty;
  logic [CNT_W-1:0] shd_div;
  logic [CNT_W-1:0] shd_duty;

  logic             cfg_good;
  logic             xfer;
  logic             accept;
  logic             reject;
  logic             wrap;
  logic             run;
  logic             load_cfg;
  logic             load_shadow;
  logic             apply_shadow;

  assign cfg_good = cfg_ok(CFG_ARG_W'(i_cfg_div), CFG_ARG_W'(i_cfg_duty));

  // Readiness is a pure function of state, so the transfer terms are built from state
  // directly rather than from o_cfg_ready to keep the combinational paths acyclic.
  assign xfer   = i_cfg_valid && (state != PEND);
  assign accept = xfer && cfg_good;
  assign reject = xfer && !cfg_good;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: halting always wins; a pending config resolves at the wrap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_en) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!i_en) begin
          state_nxt = IDLE;
        end else if (accept) begin
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (!i_en) begin
          state_nxt = IDLE;
        end else if (wrap) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Per-state outputs and config-register load strobes.
  always_comb begin
    o_cfg_ready  = 1'b1;
    o_busy       = 1'b0;
    run          = 1'b0;
    load_cfg     = 1'b0;
    load_shadow  = 1'b0;
    apply_shadow = 1'b0;
    case (state)
      IDLE: begin
        load_cfg = accept;
      end
      RUN: begin
        o_busy = 1'b1;
        run    = i_en;
        if (accept) begin
          load_shadow = i_en;
          load_cfg    = !i_en;
        end
      end
      PEND: begin
        o_cfg_ready  = 1'b0;
        o_busy       = 1'b1;
        run          = i_en;
        apply_shadow = !i_en || wrap;
      end
      default: begin
        o_cfg_ready = 1'b1;
      end
    endcase
  end

  // Active config: direct load while halted (or halting), otherwise from the shadow at the wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      act_div  <= CNT_W'(DEF_DIV);
      act_duty <= CNT_W'(DEF_DUTY);
    end else if (load_cfg) begin
      act_div  <= i_cfg_div;
      act_duty <= i_cfg_duty;
    end else if (apply_shadow) begin
      act_div  <= shd_div;
      act_duty <= shd_duty;
    end
  end

  // Shadow config holds an accepted request until the current period finishes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shd_div  <= '0;
      shd_duty <= '0;
    end else if (load_shadow) begin
      shd_div  <= i_cfg_div;
      shd_duty <= i_cfg_duty;
    end
  end

  // One-cycle error pulse for a transferred config that fails the sanity check.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cfg_err <= 1'b0;
    end else begin
      o_cfg_err <= reject;
    end
  end

  assign o_cur_div  = act_div;
  assign o_cur_duty = act_duty;

  div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .run          (run),
    .act_div      (act_div),
    .act_duty     (act_duty),
    .clk_div      (o_clk_div),
    .period_start (o_period_start),
    .last         (wrap)
  );

endmodule
